gmm_model_mem_arbiter: RTL and testbench

- Shares one external model-memory command port between two requesters of the GMM foreground-detector chain.
  - Read: model fetch for the incoming pixel, feeding the GMM pipeline input.
  - Write: write-back of updated cluster data (w, rgb_mean, rgb_std) from the pipeline output.
- Arbitrates with bounded write priority and issues reads only against free response-FIFO credits.
- Buffers returned read data in an internal FIFO so memory read data is never dropped under pipeline backpressure.
- Sits between the line/frame address generator, the fg detector pipe and the DDR/on-chip model store.

---
 rtl/gmm_model_mem_arbiter_if.sv | 38 +++
 rtl/gmm_model_mem_arbiter.sv | 107 ++++++++++
 tb/tb_gmm_model_mem_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gmm_model_mem_arbiter_if.sv
// Requester, response and memory-command channels of the GMM model-memory arbiter.
// slave = arbiter side, master = surrounding pipeline and memory side.
interface gmm_model_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 120
);
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_ready;
  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    output rd_ready, wr_ready, rsp_valid, rsp_data,
           mem_valid, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_data, rsp_ready,
           mem_ready, mem_rvalid, mem_rdata,
    input  rd_ready, wr_ready, rsp_valid, rsp_data,
           mem_valid, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gmm_model_mem_arbiter.sv
// Shares one model-memory command port between model fetch (read) and write-back; grant to mem_valid is 1 cycle.
// Writes win for at most WR_STREAK_MAX grants over a pending read; reads issue only against free response-FIFO credits.
module gmm_model_mem_arbiter #(
  parameter int ADDR_WIDTH      = 21,
  parameter int DATA_WIDTH      = 120,
  parameter int MAX_OUTSTANDING = 8,
  parameter int WR_STREAK_MAX   = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  gmm_model_mem_arbiter_if.slave             bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   reserved_cnt,
  output logic                               err_overflow
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(WR_STREAK_MAX + 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  cmd_t                  cmd_q;
  logic                  mem_valid_q;
  logic [SW-1:0]         wr_streak;
  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic cmd_free, can_rd, grant_wr, grant_rd;
  logic fifo_full, fifo_empty, pop, do_push;

  assign cmd_free = ~mem_valid_q | bus.mem_ready;
  assign can_rd   = bus.rd_valid & (reserved_cnt < CW'(MAX_OUTSTANDING));
  // The write yields only when a read is actually issuable and the streak is spent.
  assign grant_wr = cmd_free & bus.wr_valid & ~(can_rd & (wr_streak == SW'(WR_STREAK_MAX)));
  assign grant_rd = cmd_free & ~grant_wr & can_rd;

  assign bus.rd_ready  = grant_rd;
  assign bus.wr_ready  = grant_wr;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_write = cmd_q.write;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;

  assign fifo_full     = (count == CW'(MAX_OUTSTANDING));
  assign fifo_empty    = (count == '0);
  assign pop           = ~fifo_empty & bus.rsp_ready;
  assign do_push       = bus.mem_rvalid & (~fifo_full | pop);
  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      cmd_q       <= '0;
      wr_streak   <= '0;
    end else if (cmd_free) begin
      mem_valid_q <= grant_wr | grant_rd;
      if (grant_wr) begin
        cmd_q     <= '{write: 1'b1, addr: bus.wr_addr, wdata: bus.wr_data};
        wr_streak <= can_rd ? wr_streak + SW'(1) : '0;
      end else if (grant_rd) begin
        cmd_q     <= '{write: 1'b0, addr: bus.rd_addr, wdata: '0};
        wr_streak <= '0;
      end
    end
  end

  // Credits cover both reads in flight and entries parked in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_cnt <= '0;
    end else begin
      case ({grant_rd, pop})
        2'b10:   reserved_cnt <= reserved_cnt + CW'(1);
        2'b01:   reserved_cnt <= reserved_cnt - CW'(1);
        default: reserved_cnt <= reserved_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem[i] <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.mem_rvalid & fifo_full & ~pop) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gmm_model_mem_arbiter.sv
// Directed bench for gmm_model_mem_arbiter: reset, single read, write streak, credits, stall, overflow.
module tb_gmm_model_mem_arbiter;
  localparam int AW = 21;
  localparam int DW = 120;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    reserved_cnt;
  logic          err_overflow;
  int            pass_cnt = 0;
  int            total = 0;

  gmm_model_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gmm_model_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(8), .WR_STREAK_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .reserved_cnt(reserved_cnt), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DW-1:0] dat [8];
  logic [DW-1:0] d_a, d_x, d_y, d_z, w5, w6, e;
  logic [9:0]    rg, wg;
  logic          stall_ok;

  initial begin
    for (int k = 0; k < 8; k++) dat[k] = (DW'(k + 1) << 100) | DW'(32'h00BE_EF00 + k);
    d_a = 120'h1F0_0000_CAFE;
    d_x = 120'hAAAA_5555;
    d_y = 120'hDEAD_DEAD;
    d_z = 120'h5A5A_0001;
    w5  = 120'h0AB_1234_5678;
    w6  = 120'h0CD_8765_4321;

    rst_n = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsp_ready = 1'b0; bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // reset values
    @(negedge clk);
    nxt();
    chk("rst_mem_valid", bus.mem_valid, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_reserved", reserved_cnt, 4'd0);
    chk("rst_err", err_overflow, 1'b0);
    rst_n = 1'b1;

    // single read of 0x1F0, memory latency 5
    bus.rd_valid = 1'b1; bus.rd_addr = 21'h1F0; bus.mem_ready = 1'b1;
    #1;
    chk("a_rd_ready", bus.rd_ready, 1'b1);
    chk("a_wr_ready", bus.wr_ready, 1'b0);
    nxt();
    chk("a_mem_valid", bus.mem_valid, 1'b1);
    chk("a_mem_write", bus.mem_write, 1'b0);
    chk("a_mem_addr", bus.mem_addr, 21'h1F0);
    chk("a_reserved_1", reserved_cnt, 4'd1);
    bus.rd_valid = 1'b0;
    nxt();
    chk("a_mem_idle", bus.mem_valid, 1'b0);
    repeat (4) nxt();
    chk("a_rsp_not_yet", bus.rsp_valid, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = d_a;
    nxt();
    bus.mem_rvalid = 1'b0;
    chk("a_rsp_valid", bus.rsp_valid, 1'b1);
    chk("a_rsp_data", bus.rsp_data, d_a);
    chk("a_reserved_held", reserved_cnt, 4'd1);
    bus.rsp_ready = 1'b1;
    nxt();
    bus.rsp_ready = 1'b0;
    chk("a_reserved_0", reserved_cnt, 4'd0);
    chk("a_rsp_drained", bus.rsp_valid, 1'b0);

    // write streak: W,W,W,W,R repeating
    bus.wr_valid = 1'b1; bus.wr_addr = 21'h100; bus.wr_data = w6;
    bus.rd_valid = 1'b1; bus.rd_addr = 21'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      rg[i] = bus.rd_ready;
      wg[i] = bus.wr_ready;
      nxt();
    end
    chk("b_rd_pattern", rg, 10'b10000_10000);
    chk("b_wr_pattern", wg, 10'b01111_01111);
    chk("b_reserved_2", reserved_cnt, 4'd2);

    // credits exhausted: writes only
    repeat (40) nxt();
    #1;
    chk("c_reserved_8", reserved_cnt, 4'd8);
    chk("c_rd_blocked", bus.rd_ready, 1'b0);
    chk("c_wr_flows", bus.wr_ready, 1'b1);
    chk("c_no_err", err_overflow, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = dat[k];
      nxt();
    end
    bus.mem_rvalid = 1'b0;
    chk("c_fifo_head", bus.rsp_data, dat[0]);
    chk("c_reserved_full", reserved_cnt, 4'd8);
    chk("c_no_err_full", err_overflow, 1'b0);

    // one pop frees a credit only on the following cycle
    bus.wr_valid = 1'b0; bus.rsp_ready = 1'b1;
    #1;
    chk("d_same_cycle_no_credit", bus.rd_ready, 1'b0);
    nxt();
    bus.rsp_ready = 1'b0;
    chk("d_reserved_7", reserved_cnt, 4'd7);
    #1;
    chk("d_rd_eligible", bus.rd_ready, 1'b1);
    nxt();
    bus.rd_valid = 1'b0;
    chk("d_reserved_8", reserved_cnt, 4'd8);

    // overflow: push into a full FIFO with no pop
    bus.mem_rvalid = 1'b1; bus.mem_rdata = d_x;
    nxt();
    chk("f_fill_no_err", err_overflow, 1'b0);
    bus.mem_rdata = d_y;
    nxt();
    bus.mem_rvalid = 1'b0;
    chk("f_err_set", err_overflow, 1'b1);
    chk("f_head_kept", bus.rsp_data, dat[1]);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 7) e = dat[k + 1];
      else e = d_x;
      chk($sformatf("f_drain_%0d", k), bus.rsp_data, e);
      nxt();
    end
    bus.rsp_ready = 1'b0;
    chk("f_empty", bus.rsp_valid, 1'b0);
    chk("f_reserved_0", reserved_cnt, 4'd0);
    chk("f_err_sticky", err_overflow, 1'b1);

    // memory stall holds the command
    bus.wr_valid = 1'b1; bus.wr_addr = 21'h0AB; bus.wr_data = w5; bus.mem_ready = 1'b0;
    nxt();
    chk("e_mem_valid", bus.mem_valid, 1'b1);
    chk("e_mem_write", bus.mem_write, 1'b1);
    chk("e_mem_addr", bus.mem_addr, 21'h0AB);
    bus.wr_addr = 21'h0CD; bus.wr_data = w6; bus.rd_valid = 1'b1; bus.rd_addr = 21'h300;
    stall_ok = 1'b1;
    repeat (10) begin
      #1;
      if (bus.mem_addr !== 21'h0AB || bus.mem_wdata !== w5 || bus.rd_ready !== 1'b0 ||
          bus.wr_ready !== 1'b0 || bus.mem_valid !== 1'b1) stall_ok = 1'b0;
      nxt();
    end
    chk("e_stall_stable", stall_ok, 1'b1);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.mem_ready = 1'b1;
    nxt();
    chk("e_issued_once", bus.mem_valid, 1'b0);

    // reset mid-stream with 3 reads in flight
    bus.rd_valid = 1'b1;
    repeat (3) nxt();
    bus.rd_valid = 1'b0;
    chk("g_reserved_3", reserved_cnt, 4'd3);
    rst_n = 1'b0;
    #1;
    chk("g_rst_mem_valid", bus.mem_valid, 1'b0);
    chk("g_rst_reserved", reserved_cnt, 4'd0);
    chk("g_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("g_rst_err", err_overflow, 1'b0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("g_err_after", err_overflow, 1'b0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = d_z;
    nxt();
    bus.mem_rvalid = 1'b0;
    chk("g_stale_push_valid", bus.rsp_valid, 1'b1);
    chk("g_stale_push_data", bus.rsp_data, d_z);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
